// File: rtl/audio_avg_filter.sv
// Moving-average stage between codec read and write sides: one read pop yields one write push.
// Keeps a 2^LOG2_TAPS sample history per channel and outputs the floored running-sum average.
module audio_avg_filter #(
    parameter int unsigned DATA_W    = 24,
    parameter int unsigned LOG2_TAPS = 3
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              filter_en,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    input  logic              write_ready,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              write
);

    localparam int unsigned Taps = 1 << LOG2_TAPS;
    localparam int unsigned SumW = DATA_W + LOG2_TAPS;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StCapture = 3'd1;
    localparam logic [2:0] StUpdate  = 3'd2;
    localparam logic [2:0] StHold    = 3'd3;
    localparam logic [2:0] StWaitWr  = 3'd4;
    localparam logic [2:0] StWrite   = 3'd5;

    logic [2:0]                state_q, state_d;
    logic                      read_q, read_d;
    logic                      write_q, write_d;
    logic [DATA_W-1:0]         new_l_q, new_l_d, new_r_q, new_r_d;
    logic [DATA_W-1:0]         hist_l_q [Taps];
    logic [DATA_W-1:0]         hist_l_d [Taps];
    logic [DATA_W-1:0]         hist_r_q [Taps];
    logic [DATA_W-1:0]         hist_r_d [Taps];
    logic signed [SumW-1:0]    sum_l_q, sum_l_d, sum_r_q, sum_r_d;
    logic [LOG2_TAPS-1:0]      wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0]         wdata_l_q, wdata_l_d, wdata_r_q, wdata_r_d;
    logic signed [SumW-1:0]    avg_l_full, avg_r_full;

    function automatic logic signed [SumW-1:0] sext(input logic [DATA_W-1:0] x);
        return SumW'(signed'(x));
    endfunction

    // Arithmetic shift floors toward minus infinity; upper bits are dropped on output.
    assign avg_l_full = sum_l_q >>> LOG2_TAPS;
    assign avg_r_full = sum_r_q >>> LOG2_TAPS;

    always_comb begin
        state_d   = state_q;
        read_d    = 1'b0;
        write_d   = 1'b0;
        new_l_d   = new_l_q;
        new_r_d   = new_r_q;
        hist_l_d  = hist_l_q;
        hist_r_d  = hist_r_q;
        sum_l_d   = sum_l_q;
        sum_r_d   = sum_r_q;
        wr_ptr_d  = wr_ptr_q;
        wdata_l_d = wdata_l_q;
        wdata_r_d = wdata_r_q;
        case (state_q)
            StIdle: begin
                if (read_ready) begin
                    read_d  = 1'b1;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                new_l_d = readdata_left;
                new_r_d = readdata_right;
                state_d = StUpdate;
            end
            StUpdate: begin
                sum_l_d            = sum_l_q + sext(new_l_q) - sext(hist_l_q[wr_ptr_q]);
                sum_r_d            = sum_r_q + sext(new_r_q) - sext(hist_r_q[wr_ptr_q]);
                hist_l_d[wr_ptr_q] = new_l_q;
                hist_r_d[wr_ptr_q] = new_r_q;
                wr_ptr_d           = wr_ptr_q + LOG2_TAPS'(1);
                state_d            = StHold;
            end
            StHold: begin
                wdata_l_d = filter_en ? avg_l_full[DATA_W-1:0] : new_l_q;
                wdata_r_d = filter_en ? avg_r_full[DATA_W-1:0] : new_r_q;
                state_d   = StWaitWr;
            end
            StWaitWr: begin
                if (write_ready) begin
                    write_d = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q   <= StIdle;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            new_l_q   <= '0;
            new_r_q   <= '0;
            hist_l_q  <= '{default: '0};
            hist_r_q  <= '{default: '0};
            sum_l_q   <= '0;
            sum_r_q   <= '0;
            wr_ptr_q  <= '0;
            wdata_l_q <= '0;
            wdata_r_q <= '0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            write_q   <= write_d;
            new_l_q   <= new_l_d;
            new_r_q   <= new_r_d;
            hist_l_q  <= hist_l_d;
            hist_r_q  <= hist_r_d;
            sum_l_q   <= sum_l_d;
            sum_r_q   <= sum_r_d;
            wr_ptr_q  <= wr_ptr_d;
            wdata_l_q <= wdata_l_d;
            wdata_r_q <= wdata_r_d;
        end
    end

    assign read            = read_q;
    assign write           = write_q;
    assign writedata_left  = wdata_l_q;
    assign writedata_right = wdata_r_q;

endmodule

// File: tb/tb_audio_avg_filter.sv
// Bench for audio_avg_filter: directed and random samples against a sliding-window average model.
module tb_audio_avg_filter;

    localparam int unsigned DW = 24;
    localparam int unsigned LT = 3;
    localparam int          N  = 1 << LT;

    logic          clk = 1'b0;
    logic          reset;
    logic          filter_en;
    logic          read_ready;
    logic [DW-1:0] readdata_left, readdata_right;
    logic          read;
    logic          write_ready;
    logic [DW-1:0] writedata_left, writedata_right;
    logic          write;

    int n_chk  = 0;
    int n_pass = 0;

    longint hl[$];
    longint hr[$];

    always #5 clk = ~clk;

    audio_avg_filter #(.DATA_W(DW), .LOG2_TAPS(LT)) dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .filter_en      (filter_en),
        .read_ready     (read_ready),
        .readdata_left  (readdata_left),
        .readdata_right (readdata_right),
        .read           (read),
        .write_ready    (write_ready),
        .writedata_left (writedata_left),
        .writedata_right(writedata_right),
        .write          (write)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: window of the last N inputs, average = floor(sum / N).
    task automatic model_reset();
        hl = {};
        hr = {};
        for (int i = 0; i < N; i++) begin
            hl.push_back(0);
            hr.push_back(0);
        end
    endtask

    function automatic logic [DW-1:0] floor_avg(input longint s);
        longint a;
        a = (s >= 0) ? s / N : -((-s + N - 1) / N);
        return DW'(a);
    endfunction

    task automatic model_push(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit en,
                              output logic [DW-1:0] el, output logic [DW-1:0] er);
        longint sl, sr;
        hl.push_back(longint'(signed'(l)));
        hr.push_back(longint'(signed'(r)));
        void'(hl.pop_front());
        void'(hr.pop_front());
        sl = 0;
        sr = 0;
        foreach (hl[i]) sl += hl[i];
        foreach (hr[i]) sr += hr[i];
        el = en ? floor_avg(sl) : l;
        er = en ? floor_avg(sr) : r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    // One full transaction with write_ready held high; checks pulse count, latency and data.
    task automatic run_sample(input string tag, input logic [DW-1:0] l, input logic [DW-1:0] r,
                              input bit en);
        logic [DW-1:0] el, er, gl, gr;
        int rd_cnt, rd_t, wr_t;
        bit got;
        model_push(l, r, en, el, er);
        readdata_left  = l;
        readdata_right = r;
        filter_en      = en;
        write_ready    = 1'b1;
        read_ready     = 1'b1;
        rd_cnt = 0;
        rd_t   = 0;
        wr_t   = 0;
        got    = 1'b0;
        gl     = '0;
        gr     = '0;
        for (int c = 1; c <= 30 && !got; c++) begin
            tick();
            if (read) begin
                rd_cnt++;
                rd_t = c;
                read_ready = 1'b0;
            end
            if (write) begin
                got  = 1'b1;
                wr_t = c;
                gl   = writedata_left;
                gr   = writedata_right;
            end
        end
        chk({tag, " write seen"}, 64'(got), 64'(1));
        chk({tag, " read pulses"}, 64'(rd_cnt), 64'(1));
        chk({tag, " latency"}, 64'(wr_t - rd_t), 64'(4));
        chk({tag, " left"}, 64'(gl), 64'(el));
        chk({tag, " right"}, 64'(gr), 64'(er));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rd_cnt, wr_cnt, both_cnt;
        logic [DW-1:0] el, er, hold_l, hold_r, rl, rr;
        reset          = 1'b1;
        filter_en      = 1'b1;
        read_ready     = 1'b0;
        write_ready    = 1'b0;
        readdata_left  = '0;
        readdata_right = '0;
        do_reset();

        chk("reset read", 64'(read), 64'(0));
        chk("reset write", 64'(write), 64'(0));
        chk("reset wdata", 64'({writedata_left, writedata_right}), 64'(0));

        // Reset mid-WAIT_WR drops the pending sample.
        readdata_left  = 24'h000800;
        readdata_right = 24'h000800;
        read_ready     = 1'b1;
        for (int c = 0; c < 20 && !read; c++) tick();
        read_ready = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        do_reset();
        chk("midrst read", 64'(read), 64'(0));
        chk("midrst write", 64'(write), 64'(0));
        chk("midrst wdata", 64'({writedata_left, writedata_right}), 64'(0));
        write_ready = 1'b1;
        wr_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (write) wr_cnt++;
        end
        chk("midrst dropped", 64'(wr_cnt), 64'(0));
        run_sample("post-reset", 24'h000800, 24'h000800, 1'b1);
        chk("post-reset abs", 64'(writedata_left), 64'(24'h000100));

        // Step response ramps up then saturates at the input value.
        do_reset();
        for (int i = 0; i < 9; i++) run_sample("step", 24'h000800, 24'h000800, 1'b1);
        chk("step final abs", 64'(writedata_right), 64'(24'h000800));

        // Negative step and floor of -1.
        do_reset();
        for (int i = 0; i < 8; i++) run_sample("neg", 24'hFFF800, 24'hFFF800, 1'b1);
        chk("neg final abs", 64'(writedata_left), 64'(24'hFFF800));
        do_reset();
        run_sample("floor", 24'hFFFFFF, 24'hFFFFFF, 1'b1);
        chk("floor abs", 64'(writedata_left), 64'(24'hFFFFFF));

        // Impulse stays in the window for exactly N outputs.
        do_reset();
        run_sample("impulse", 24'h7FFFF8, 24'h7FFFF8, 1'b1);
        for (int i = 0; i < 8; i++) run_sample("wrap", 24'h000000, 24'h000000, 1'b1);
        chk("wrap final abs", 64'(writedata_left), 64'(0));

        // Backpressure: one read, no write, stable data, then a single write pulse.
        model_push(24'h000400, 24'hFFFC00, 1'b1, el, er);
        readdata_left  = 24'h000400;
        readdata_right = 24'hFFFC00;
        filter_en      = 1'b1;
        write_ready    = 1'b0;
        read_ready     = 1'b1;
        rd_cnt   = 0;
        wr_cnt   = 0;
        both_cnt = 0;
        hold_l   = '0;
        hold_r   = '0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (read) rd_cnt++;
            if (write) wr_cnt++;
            if (c == 10) begin
                hold_l = writedata_left;
                hold_r = writedata_right;
            end
        end
        chk("bp reads", 64'(rd_cnt), 64'(1));
        chk("bp writes", 64'(wr_cnt), 64'(0));
        chk("bp stable left", 64'(writedata_left), 64'(hold_l));
        chk("bp stable right", 64'(writedata_right), 64'(hold_r));
        read_ready  = 1'b0;
        write_ready = 1'b1;
        wr_cnt = 0;
        rl     = '0;
        rr     = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (write) begin
                wr_cnt++;
                rl = writedata_left;
                rr = writedata_right;
            end
            if (write && read) both_cnt++;
        end
        chk("bp write pulses", 64'(wr_cnt), 64'(1));
        chk("bp left", 64'(rl), 64'(el));
        chk("bp right", 64'(rr), 64'(er));

        // Bypass echoes input but still feeds the history.
        do_reset();
        run_sample("bypass", 24'h123456, 24'hABCDEF, 1'b0);
        chk("bypass abs", 64'({writedata_left, writedata_right}), 64'({24'h123456, 24'hABCDEF}));
        run_sample("reenable", 24'h000010, 24'h000020, 1'b1);
        run_sample("reenable2", 24'h000030, 24'h000040, 1'b1);

        // Random samples with random enable.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            run_sample("random", DW'($urandom), DW'($urandom), 1'($urandom_range(0, 3) != 0));
        end
        chk("no read/write overlap", 64'(both_cnt), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
